// File: rtl/fcore_decoder_stage.sv
// fCore decode stage: splits fetched words into fields, assembles two-word LDC,
// flags illegal opcodes and parks in HALTED after STOP until a start pulse.
module fcore_decoder_stage #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 5,
    parameter int REG_ADDR_WIDTH    = 4,
    parameter int COUNTER_WIDTH     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    output logic [OPCODE_WIDTH-1:0]      dec_opcode,
    output logic [REG_ADDR_WIDTH-1:0]    dec_op_a,
    output logic [REG_ADDR_WIDTH-1:0]    dec_op_b,
    output logic [REG_ADDR_WIDTH-1:0]    dec_dest,
    output logic [INSTRUCTION_WIDTH-1:0] dec_immediate,
    output logic                         dec_illegal,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic                         halted,
    output logic                         illegal_seen,
    output logic [COUNTER_WIDTH-1:0]     issued_count
);
    localparam int OW = OPCODE_WIDTH;
    localparam int RW = REG_ADDR_WIDTH;
    localparam logic [OW-1:0] OP_LDC  = OW'(6);
    localparam logic [OW-1:0] OP_STOP = OW'(12);

    typedef enum logic [1:0] {HALTED, DECODE, WAIT_IMM, DRAIN} state_t;
    state_t state, state_nxt;

    logic [OW-1:0] w_op;
    logic [RW-1:0] w_a, w_b, w_d;
    logic          w_illegal;
    logic          accept, handshake;
    logic [RW-1:0] hold_a, hold_b, hold_d;

    assign w_op      = instr_data[OW-1:0];
    assign w_a       = instr_data[OW+RW-1:OW];
    assign w_b       = instr_data[OW+2*RW-1:OW+RW];
    assign w_d       = instr_data[OW+3*RW-1:OW+2*RW];
    assign w_illegal = (w_op == OW'(23)) || (w_op == OW'(24)) || (w_op >= OW'(27));
    assign accept    = instr_valid && instr_ready;
    assign handshake = dec_valid && dec_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= HALTED;
        else        state <= state_nxt;
    end

    // DRAIN holds the issued STOP until downstream takes it; no words enter meanwhile.
    always_comb begin
        state_nxt = state;
        case (state)
            HALTED:   if (start) state_nxt = DECODE;
            DECODE:   if (accept) begin
                          if (w_op == OP_LDC)       state_nxt = WAIT_IMM;
                          else if (w_op == OP_STOP) state_nxt = DRAIN;
                      end
            WAIT_IMM: if (accept) state_nxt = DECODE;
            DRAIN:    if (handshake) state_nxt = HALTED;
            default:  state_nxt = HALTED;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        halted      = 1'b0;
        case (state)
            HALTED:           halted = 1'b1;
            DECODE, WAIT_IMM: instr_ready = !dec_valid || dec_ready;
            default:          instr_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_valid     <= 1'b0;
            dec_opcode    <= '0;
            dec_op_a      <= '0;
            dec_op_b      <= '0;
            dec_dest      <= '0;
            dec_immediate <= '0;
            dec_illegal   <= 1'b0;
            hold_a        <= '0;
            hold_b        <= '0;
            hold_d        <= '0;
        end else begin
            if (handshake) dec_valid <= 1'b0;
            if (accept) begin
                if (state == WAIT_IMM) begin
                    dec_valid     <= 1'b1;
                    dec_opcode    <= OP_LDC;
                    dec_op_a      <= hold_a;
                    dec_op_b      <= hold_b;
                    dec_dest      <= hold_d;
                    dec_immediate <= instr_data;
                    dec_illegal   <= 1'b0;
                end else if (w_op == OP_LDC) begin
                    hold_a <= w_a;
                    hold_b <= w_b;
                    hold_d <= w_d;
                end else begin
                    dec_valid     <= 1'b1;
                    dec_opcode    <= w_op;
                    dec_op_a      <= w_a;
                    dec_op_b      <= w_b;
                    dec_dest      <= w_d;
                    dec_immediate <= '0;
                    dec_illegal   <= w_illegal;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issued_count <= '0;
            illegal_seen <= 1'b0;
        end else if (state == HALTED && start) begin
            issued_count <= '0;
            illegal_seen <= 1'b0;
        end else if (handshake) begin
            issued_count <= issued_count + COUNTER_WIDTH'(1);
            if (dec_illegal) illegal_seen <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fcore_decoder_stage.sv
// Randomized and directed bench for fcore_decoder_stage against a
// transaction-level reference model of the decode rules.
module tb_fcore_decoder_stage;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, reset4, start, instr_valid, dec_ready;
    logic [31:0] instr_data;
    logic        instr_ready, dec_illegal, dec_valid, halted, illegal_seen;
    logic [4:0]  dec_opcode;
    logic [3:0]  dec_op_a, dec_op_b, dec_dest;
    logic [31:0] dec_immediate;
    logic [15:0] issued_count;
    logic        r4_ready, r4_illegal, r4_valid, r4_halted, r4_seen;
    logic [4:0]  r4_opcode;
    logic [3:0]  r4_a, r4_b, r4_d, r4_count;
    logic [31:0] r4_imm;

    fcore_decoder_stage dut (
        .clock(clock), .reset(reset), .start(start), .instr_data(instr_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .dec_opcode(dec_opcode),
        .dec_op_a(dec_op_a), .dec_op_b(dec_op_b), .dec_dest(dec_dest),
        .dec_immediate(dec_immediate), .dec_illegal(dec_illegal), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .halted(halted), .illegal_seen(illegal_seen),
        .issued_count(issued_count));

    fcore_decoder_stage #(.COUNTER_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset4), .start(start), .instr_data(instr_data),
        .instr_valid(instr_valid), .instr_ready(r4_ready), .dec_opcode(r4_opcode),
        .dec_op_a(r4_a), .dec_op_b(r4_b), .dec_dest(r4_d),
        .dec_immediate(r4_imm), .dec_illegal(r4_illegal), .dec_valid(r4_valid),
        .dec_ready(dec_ready), .halted(r4_halted), .illegal_seen(r4_seen),
        .issued_count(r4_count));

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: halted, STOP awaiting handshake, LDC half-assembled, output slot
    bit        m_halt, m_drain, m_pend, m_v, m_ill, m_seen, chk4;
    int        m_op, m_a, m_b, m_d, h_a, h_b, h_d, m_cnt;
    bit [31:0] m_imm;

    function automatic logic [31:0] mk(input int op, input int a, input int b, input int d);
        logic [14:0] up;
        up = 15'($urandom);
        return {up, 4'(d), 4'(b), 4'(a), 5'(op)};
    endfunction

    function automatic bit illegal_op(input int op);
        return op == 23 || op == 24 || op >= 27;
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic s);
        bit er, hs, acc, was_halt;
        int op;
        instr_valid = v; instr_data = d; dec_ready = r; start = s;
        er = !m_halt && !m_drain && (!m_v || r);
        #1 check("instr_ready", instr_ready, er);
        @(posedge clock);
        hs = m_v && r; acc = er && v; was_halt = m_halt;
        op = int'(d[4:0]);
        if (hs) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_ill) m_seen = 1;
            if (m_drain) begin m_drain = 0; m_halt = 1; end
            m_v = 0;
        end
        if (s && was_halt) begin m_halt = 0; m_cnt = 0; m_seen = 0; end
        if (acc) begin
            if (m_pend) begin
                m_pend = 0; m_v = 1; m_op = 6; m_a = h_a; m_b = h_b; m_d = h_d;
                m_imm = d; m_ill = 0;
            end else if (op == 6) begin
                m_pend = 1; h_a = int'(d[8:5]); h_b = int'(d[12:9]); h_d = int'(d[16:13]);
            end else begin
                m_v = 1; m_op = op; m_a = int'(d[8:5]); m_b = int'(d[12:9]);
                m_d = int'(d[16:13]); m_imm = 0; m_ill = illegal_op(op);
                if (op == 12) m_drain = 1;
            end
        end
        #1;
        check("dec_valid", dec_valid, m_v);
        check("halted", halted, m_halt);
        check("illegal_seen", illegal_seen, m_seen);
        check("issued_count", issued_count, m_cnt);
        if (chk4) check("count4", r4_count, m_cnt % 16);
        if (m_v) begin
            check("opcode", dec_opcode, m_op);
            check("op_a", dec_op_a, m_a);
            check("op_b", dec_op_b, m_b);
            check("dest", dec_dest, m_d);
            check("immediate", dec_immediate, m_imm);
            check("dec_illegal", dec_illegal, m_ill);
        end
    endtask

    initial begin
        int ops[10] = '{0, 1, 2, 3, 6, 12, 23, 24, 27, 31};
        int op;
        reset = 0; reset4 = 0; start = 0; instr_valid = 0; instr_data = 0; dec_ready = 0;
        m_halt = 1; m_drain = 0; m_pend = 0; m_v = 0; m_ill = 0; m_seen = 0; m_cnt = 0;
        m_op = 0; m_a = 0; m_b = 0; m_d = 0; h_a = 0; h_b = 0; h_d = 0; m_imm = 0; chk4 = 1;
        #12;
        check("rst_halted", halted, 1);
        check("rst_valid", dec_valid, 0);
        check("rst_ready", instr_ready, 0);
        check("rst_count", issued_count, 0);
        check("rst_seen", illegal_seen, 0);
        check("rst_fields", {dec_opcode, dec_op_a, dec_op_b, dec_dest, dec_immediate, dec_illegal}, 0);
        reset = 1; reset4 = 1;
        @(posedge clock); #1;

        // ADD / SUB stream
        step(0, 0, 1, 1);
        step(1, mk(1, 1, 2, 3), 1, 0);
        check("add_fields", {dec_valid, dec_opcode, dec_op_a, dec_op_b, dec_dest}, {1'b1, 5'd1, 4'd1, 4'd2, 4'd3});
        step(1, mk(2, 4, 5, 6), 1, 0);
        step(0, 0, 1, 0);
        check("two_issued", issued_count, 2);

        // LDC assembly
        step(1, mk(6, 5, 0, 0), 1, 0);
        check("ldc_gap", dec_valid, 0);
        step(1, 32'h3F80_0000, 1, 0);
        check("ldc_issue", {dec_opcode, dec_op_a, dec_immediate}, {5'd6, 4'd5, 32'h3F80_0000});
        step(0, 0, 1, 0);
        check("ldc_count", issued_count, 3);

        // Backpressure
        step(1, mk(1, 7, 8, 9), 1, 0);
        for (int i = 0; i < 4; i++) step(1, mk(2, 10, 11, 12), 0, 0);
        check("bp_hold", {dec_opcode, dec_op_a}, {5'd1, 4'd7});
        step(1, mk(2, 10, 11, 12), 1, 0);
        check("bp_next", {dec_opcode, dec_op_a}, {5'd2, 4'd10});
        step(0, 0, 1, 0);

        // Illegal opcodes
        step(1, mk(27, 1, 1, 1), 1, 0);
        step(1, mk(24, 2, 2, 2), 1, 0);
        step(0, 0, 1, 0);
        check("seen_set", illegal_seen, 1);

        // STOP then ADD; start outside HALTED and in the STOP handshake cycle
        step(1, mk(12, 0, 0, 0), 0, 1);
        step(1, mk(1, 3, 3, 3), 1, 1);
        check("stop_halt", halted, 1);
        step(1, mk(1, 3, 3, 3), 1, 0);
        check("halt_seen", illegal_seen, 1);
        step(1, mk(1, 3, 3, 3), 1, 1);
        check("restart_cnt", issued_count, 0);
        step(1, mk(1, 3, 3, 3), 1, 0);
        step(0, 0, 1, 0);
        check("restart_one", issued_count, 1);

        // 17 NOPs: the 4-bit counter wraps to 1
        step(1, mk(12, 0, 0, 0), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 17; i++) step(1, mk(0, i, i, i), 1, 0);
        step(0, 0, 1, 0);
        check("nop17", issued_count, 17);
        check("nop17_w4", r4_count, 1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            op = ($urandom % 4 == 0) ? int'($urandom % 32) : ops[$urandom % 10];
            if (op == 12 && $urandom % 3 != 0) op = 1;
            step($urandom % 4 != 0, mk(op, $urandom, $urandom, $urandom), $urandom % 4 != 0,
                 m_halt ? ($urandom % 3 == 0) : ($urandom % 10 == 0));
        end

        // Reset the narrow instance in the middle of an LDC
        while (m_halt || m_drain || m_pend) step(0, 0, 1, m_halt);
        step(1, mk(6, 9, 0, 0), 1, 0);
        chk4 = 0;
        check("w4_pre_halt", r4_halted, 0);
        reset4 = 0;
        #1;
        check("w4_rst_halt", r4_halted, 1);
        check("w4_rst_valid", r4_valid, 0);
        check("w4_rst_ready", r4_ready, 0);
        reset4 = 1;
        step(0, 0, 1, 1);
        step(1, 32'h3F80_0000, 1, 0);
        check("w4_no_imm", {r4_valid, r4_opcode, r4_imm}, {1'b1, 5'd0, 32'd0});
        check("w4_count0", r4_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
